// File: rtl/csc_mat_pipe_if.sv
// Beat handshake bundle for csc_mat_pipe: input beat (valid/ready) and output beat (valid/ready).
// Signal names follow the DUT's point of view (i_ = into the pipe, o_ = out of it).
interface csc_mat_pipe_if #(
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int OUTPUT_DATA_WIDTH = 8
);
    logic                                i_valid;
    logic signed [INPUT_DATA_WIDTH-1:0]  i_x0, i_x1, i_x2;
    logic                                o_ready;
    logic                                o_valid;
    logic signed [OUTPUT_DATA_WIDTH-1:0] o_y0, o_y1, o_y2;
    logic                                i_ready;

    modport slave (
        input  i_valid, i_x0, i_x1, i_x2, i_ready,
        output o_ready, o_valid, o_y0, o_y1, o_y2
    );

    modport master (
        output i_valid, i_x0, i_x1, i_x2, i_ready,
        input  o_ready, o_valid, o_y0, o_y1, o_y2
    );
endinterface

// File: rtl/csc_mat_pipe.sv
// 3x3 colour-space matrix with bias, 3-stage stallable pipeline, shadow/active coefficient sets.
// Optional: define CSC_MAT_PIPE_BYPASS_EN to add i_bypass (beat passes x through, saturated).

module csc_mat_row #(
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int CSC_WIDTH         = 10,
    parameter int BIAS_WIDTH        = 8,
    parameter int FRAC_BITS         = 8
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                i_adv,
    input  logic [2:0][INPUT_DATA_WIDTH-1:0]    i_x,
    input  logic [INPUT_DATA_WIDTH-1:0]         i_xb,
    input  logic [2:0][CSC_WIDTH-1:0]           i_coef,
    input  logic [BIAS_WIDTH-1:0]               i_bias,
    input  logic                                i_byp1,
    output logic [OUTPUT_DATA_WIDTH-1:0]        o_y
);
    localparam int PW = INPUT_DATA_WIDTH + CSC_WIDTH;
    localparam int W  = INPUT_DATA_WIDTH + CSC_WIDTH + 3;
    // Half an LSB of the output; collapses to zero when FRAC_BITS is 0.
    localparam logic signed [W-1:0] RND   = (W'(1) << FRAC_BITS) >> 1;
    localparam logic signed [W-1:0] Y_MAX = (W'(1) << (OUTPUT_DATA_WIDTH - 1)) - W'(1);
    localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

    logic signed [PW-1:0]               r_p [3];
    logic signed [INPUT_DATA_WIDTH-1:0] r_xb;
    logic signed [W-1:0]                r_s;
    logic signed [W-1:0]                w_s;
    logic signed [W-1:0]                w_sh;
    logic signed [W-1:0]                w_bias;
    logic signed [W-1:0]                w_xb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < 3; c++) r_p[c] <= '0;
            r_xb <= '0;
        end else if (i_adv) begin
            for (int c = 0; c < 3; c++)
                r_p[c] <= PW'($signed(i_x[c])) * PW'($signed(i_coef[c]));
            r_xb <= $signed(i_xb);
        end
    end

    // Bypassed beats are lifted to the same fixed point so stage 3 is shared.
    always_comb begin
        w_bias = W'($signed(i_bias));
        w_xb   = W'(r_xb);
        w_s    = RND + (w_bias <<< FRAC_BITS);
        for (int c = 0; c < 3; c++) w_s = w_s + W'(r_p[c]);
        if (i_byp1) w_s = w_xb <<< FRAC_BITS;
    end

    assign w_sh = r_s >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s <= '0;
            o_y <= '0;
        end else if (i_adv) begin
            r_s <= w_s;
            if (w_sh > Y_MAX)      o_y <= Y_MAX[OUTPUT_DATA_WIDTH-1:0];
            else if (w_sh < Y_MIN) o_y <= Y_MIN[OUTPUT_DATA_WIDTH-1:0];
            else                   o_y <= w_sh[OUTPUT_DATA_WIDTH-1:0];
        end
    end
endmodule

module csc_mat_pipe #(
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int CSC_WIDTH         = 10,
    parameter int BIAS_WIDTH        = 8,
    parameter int FRAC_BITS         = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    csc_mat_pipe_if.slave               io_bus,
    input  logic signed [CSC_WIDTH-1:0] i_coef00, i_coef01, i_coef02,
    input  logic signed [CSC_WIDTH-1:0] i_coef10, i_coef11, i_coef12,
    input  logic signed [CSC_WIDTH-1:0] i_coef20, i_coef21, i_coef22,
    input  logic signed [BIAS_WIDTH-1:0] i_bias0, i_bias1, i_bias2,
    input  logic                        i_coef_load,
`ifdef CSC_MAT_PIPE_BYPASS_EN
    input  logic                        i_bypass,
`endif
    output logic                        o_coef_pending
);
    typedef logic [2:0][2:0][CSC_WIDTH-1:0] coef_set_t;
    typedef logic [2:0][BIAS_WIDTH-1:0]     bias_set_t;

    localparam logic [CSC_WIDTH-1:0] ONE = CSC_WIDTH'(1) << FRAC_BITS;

    function automatic coef_set_t ident_set();
        coef_set_t s;
        s = '0;
        for (int r = 0; r < 3; r++) s[r][r] = ONE;
        return s;
    endfunction

    localparam coef_set_t IDENT = ident_set();

    if (FRAC_BITS > CSC_WIDTH - 2) begin : g_bad_frac
        $error("csc_mat_pipe: FRAC_BITS must not exceed CSC_WIDTH-2");
    end

    coef_set_t r_act_coef, r_sh_coef, w_in_coef;
    bias_set_t r_act_bias, r_sh_bias, w_in_bias;
    logic      r_pend;
    logic [3:1] r_vld;
    logic      w_adv, w_acc, w_empty, w_upd, w_byp1;
    logic [2:0][INPUT_DATA_WIDTH-1:0]  w_x;
    logic [2:0][OUTPUT_DATA_WIDTH-1:0] w_y;

    assign w_in_coef = {{i_coef22, i_coef21, i_coef20},
                        {i_coef12, i_coef11, i_coef10},
                        {i_coef02, i_coef01, i_coef00}};
    assign w_in_bias = {i_bias2, i_bias1, i_bias0};
    assign w_x       = {io_bus.i_x2, io_bus.i_x1, io_bus.i_x0};

    // Whole pipe moves in lockstep; a pending set blocks new beats so the swap
    // happens only once every in-flight beat has left on the old coefficients.
    assign w_adv          = !r_vld[3] || io_bus.i_ready;
    assign io_bus.o_ready = w_adv && !r_pend;
    assign w_acc          = io_bus.i_valid && io_bus.o_ready;
    assign w_empty        = ~|r_vld;
    assign w_upd          = r_pend && w_empty && !w_acc && !i_coef_load;
    assign io_bus.o_valid = r_vld[3];
    assign o_coef_pending = r_pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_vld <= '0;
        else if (w_adv) r_vld <= {r_vld[2:1], w_acc};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh_coef  <= IDENT;
            r_act_coef <= IDENT;
            r_sh_bias  <= '0;
            r_act_bias <= '0;
            r_pend     <= 1'b0;
        end else if (i_coef_load) begin
            r_sh_coef <= w_in_coef;
            r_sh_bias <= w_in_bias;
            r_pend    <= 1'b1;
        end else if (w_upd) begin
            r_act_coef <= r_sh_coef;
            r_act_bias <= r_sh_bias;
            r_pend     <= 1'b0;
        end
    end

`ifdef CSC_MAT_PIPE_BYPASS_EN
    logic r_byp1;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_byp1 <= 1'b0;
        else if (w_adv) r_byp1 <= i_bypass;
    end
    assign w_byp1 = r_byp1;
`else
    assign w_byp1 = 1'b0;
`endif

    for (genvar r = 0; r < 3; r++) begin : g_row
        csc_mat_row #(
            .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
            .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH),
            .CSC_WIDTH        (CSC_WIDTH),
            .BIAS_WIDTH       (BIAS_WIDTH),
            .FRAC_BITS        (FRAC_BITS)
        ) u_row (
            .clk   (clk),
            .rstn  (rstn),
            .i_adv (w_adv),
            .i_x   (w_x),
            .i_xb  (w_x[r]),
            .i_coef(r_act_coef[r]),
            .i_bias(r_act_bias[r]),
            .i_byp1(w_byp1),
            .o_y   (w_y[r])
        );
    end

    assign io_bus.o_y0 = w_y[0];
    assign io_bus.o_y1 = w_y[1];
    assign io_bus.o_y2 = w_y[2];
endmodule
